// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state encodings and the parity helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TxIdle, TxStart, TxData, TxParity, TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clock, input int unsigned baud);
    int unsigned div;
    div = clock / (baud * 16);
    return (div == 0) ? 1 : div;
  endfunction

  // Narrow characters are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is taken only alongside a pop.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_core.sv
// UART with 16x oversampled TX/RX engines, TX/RX FIFOs and sticky line-error flags.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK       = 50000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 2,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic                 o_tx,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_write,
  output logic                 o_tx_full,
  output logic                 o_tx_empty,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_read,
  output logic                 o_rx_full,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun_err,
  output logic                 o_break_det,
  input  logic                 i_err_clear
);

  localparam int unsigned DIV     = calc_div(CLOCK, BAUD_RATE);
  localparam int unsigned BCW     = $clog2(DIV) + 1;
  localparam logic [4:0]  BitEnd  = 5'd15;
  localparam logic [4:0]  StopEnd = 5'(16 * STOP_BITS - 1);
  localparam logic [2:0]  LastBit = 3'(DATA_BITS - 1);
  localparam bit          HasPar  = (PARITY_MODE != PARITY_NONE);

  logic [BCW-1:0] r_baud_cnt;
  logic           w_tick;

  assign w_tick = (r_baud_cnt == BCW'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_baud_cnt <= '0;
    else          r_baud_cnt <= w_tick ? '0 : r_baud_cnt + BCW'(1);
  end

  // ---------------- transmitter ----------------
  tx_state_e            r_tx_state, w_tx_state_next;
  logic [4:0]           r_tx_tcnt;
  logic [2:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic [DATA_BITS-1:0] w_txf_data;
  logic                 w_tx_pop;
  logic                 w_tx_bit_done;
  logic                 w_tx_stop_done;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_tx_write),
    .i_data  (i_tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_txf_data),
    .o_empty (o_tx_empty),
    .o_full  (o_tx_full)
  );

  assign w_tx_bit_done  = w_tick && (r_tx_tcnt == BitEnd);
  assign w_tx_stop_done = w_tick && (r_tx_tcnt == StopEnd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_tx_state <= TxIdle;
    else          r_tx_state <= w_tx_state_next;
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    case (r_tx_state)
      TxIdle:   if (!o_tx_empty) w_tx_state_next = TxStart;
      TxStart:  if (w_tx_bit_done) w_tx_state_next = TxData;
      TxData:   if (w_tx_bit_done && r_tx_bit == LastBit)
                  w_tx_state_next = HasPar ? TxParity : TxStop;
      TxParity: if (w_tx_bit_done) w_tx_state_next = TxStop;
      TxStop:   if (w_tx_stop_done) w_tx_state_next = TxIdle;
      default:  w_tx_state_next = TxIdle;
    endcase
  end

  always_comb begin
    w_tx_pop = 1'b0;
    o_tx     = 1'b1;
    case (r_tx_state)
      TxIdle:   w_tx_pop = !o_tx_empty;
      TxStart:  o_tx = 1'b0;
      TxData:   o_tx = r_tx_shift[0];
      TxParity: o_tx = r_tx_par;
      default:  o_tx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_tcnt  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else if (w_tx_pop) begin
      r_tx_tcnt  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= w_txf_data;
      r_tx_par   <= parity_bit(8'(w_txf_data), PARITY_MODE);
    end else if (w_tick) begin
      if ((r_tx_state == TxStop) ? (r_tx_tcnt == StopEnd) : (r_tx_tcnt == BitEnd)) begin
        r_tx_tcnt <= '0;
        if (r_tx_state == TxData) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= r_tx_bit + 3'd1;
        end
      end else begin
        r_tx_tcnt <= r_tx_tcnt + 5'd1;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_e            r_rx_state, w_rx_state_next;
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  logic [3:0]           r_rx_tcnt;
  logic [2:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 w_rx_half, w_rx_sample;
  logic                 w_rx_push, w_set_frame, w_set_par, w_set_break, w_set_ovr;
  logic                 w_rxf_empty;
  logic                 r_frame_err, r_parity_err, r_overrun_err, r_break_det;

  assign w_rx_half   = w_tick && (r_rx_tcnt == 4'd7);
  assign w_rx_sample = w_tick && (r_rx_tcnt == 4'd15);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RxIdle;
    end else begin
      r_rx_s1    <= i_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_next;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      RxIdle:   if (r_rx_prev && !r_rx_s2) w_rx_state_next = RxStart;
      RxStart:  if (w_rx_half) w_rx_state_next = r_rx_s2 ? RxIdle : RxData;
      RxData:   if (w_rx_sample && r_rx_bit == LastBit)
                  w_rx_state_next = HasPar ? RxParity : RxStop;
      RxParity: if (w_rx_sample) w_rx_state_next = RxStop;
      RxStop:   if (w_rx_sample)
                  w_rx_state_next = (!r_rx_s2 && r_rx_shift == '0) ? RxBreak : RxIdle;
      RxBreak:  if (r_rx_s2) w_rx_state_next = RxIdle;
      default:  w_rx_state_next = RxIdle;
    endcase
  end

  always_comb begin
    w_rx_push   = 1'b0;
    w_set_frame = 1'b0;
    w_set_par   = 1'b0;
    w_set_break = 1'b0;
    if (r_rx_state == RxStop && w_rx_sample) begin
      if (r_rx_s2) begin
        w_rx_push = 1'b1;
        w_set_par = HasPar && (r_rx_par != parity_bit(8'(r_rx_shift), PARITY_MODE));
      end else if (r_rx_shift == '0) begin
        w_set_break = 1'b1;
      end else begin
        w_set_frame = 1'b1;
      end
    end
  end

  // The 4-bit tick count wraps on its own, giving the 16-tick spacing after the start centre.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_tcnt  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
    end else if (r_rx_state == RxIdle) begin
      r_rx_tcnt <= '0;
      r_rx_bit  <= '0;
    end else if (w_tick) begin
      r_rx_tcnt <= (r_rx_state == RxStart && r_rx_tcnt == 4'd7) ? 4'd0 : r_rx_tcnt + 4'd1;
      if (w_rx_sample && r_rx_state == RxData) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
      if (w_rx_sample && r_rx_state == RxParity) r_rx_par <= r_rx_s2;
    end
  end

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (i_rx_read),
    .o_data  (o_rx_data),
    .o_empty (w_rxf_empty),
    .o_full  (o_rx_full)
  );

  assign o_rx_valid = !w_rxf_empty;
  assign w_set_ovr  = w_rx_push && o_rx_full && !i_rx_read;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || i_err_clear) begin
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
      r_break_det   <= 1'b0;
    end else begin
      r_frame_err   <= r_frame_err   | w_set_frame;
      r_parity_err  <= r_parity_err  | w_set_par;
      r_overrun_err <= r_overrun_err | w_set_ovr;
      r_break_det   <= r_break_det   | w_set_break;
    end
  end

  assign o_frame_err   = r_frame_err;
  assign o_parity_err  = r_parity_err;
  assign o_overrun_err = r_overrun_err;
  assign o_break_det   = r_break_det;

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLOCK, default 50000000: input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: line bit rate.
REQ-003 Parameter DATA_BITS, default 8, legal 5..8: bits per character.
REQ-004 Parameter PARITY_MODE, default 2: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, legal 1..2: stop bits sent; receiver checks the first stop bit only.
REQ-006 Parameter FIFO_DEPTH, default 16, power of two >= 2: entries per TX and per RX FIFO.
REQ-007 CLK  in  1  single clock; all logic on its rising edge.
REQ-008 RST  in  1  asynchronous, active-low reset.
REQ-009 RX  in  1  serial input, asynchronous to CLK.
REQ-010 TX  out  1  serial output, idle high.
REQ-011 TX_DATA  in  DATA_BITS  character to transmit.
REQ-012 TX_WRITE  in  1  push TX_DATA into the TX FIFO.
REQ-013 TX_FULL / TX_EMPTY  out  1 each  TX FIFO status.
REQ-014 RX_DATA  out  DATA_BITS  head of the RX FIFO (first-word fall-through).
REQ-015 RX_VALID  out  1  RX FIFO not empty.
REQ-016 RX_READ  in  1  pop the RX FIFO head.
REQ-017 RX_FULL  out  1  RX FIFO full.
REQ-018 FRAME_ERR, PARITY_ERR, OVERRUN_ERR, BREAK_DET  out  1 each  sticky error flags.
REQ-019 ERR_CLEAR  in  1  clears all four sticky flags.

Function
REQ-020 Baud counter divides CLK by DIV = CLOCK/(BAUD_RATE*16), integer division, minimum 1, and emits a one-cycle tick; one bit time is 16 ticks.
REQ-021 TX FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE=0; each state holds its bit for 16 ticks, and STOP holds for 16*STOP_BITS ticks.
REQ-022 In IDLE with the TX FIFO non-empty, the TX FSM pops the head in that cycle, moves to START, and drives TX low from the next cycle; data is sent LSB first.
REQ-023 Parity bit: XOR of the data bits (even), inverted for odd.
REQ-024 From STOP, the TX FSM returns to IDLE and can start the next character back-to-back, with no extra idle bit.
REQ-025 RX passes through a 2-flop synchroniser; IDLE detects a falling edge; START re-samples after 8 ticks and returns to IDLE if the line is high (glitch, nothing recorded).
REQ-026 RX samples DATA, PARITY and STOP bits every 16 ticks after the start-bit centre.
REQ-027 Stop bit low with all data bits zero: set BREAK_DET, discard the character, wait for the line to go high before re-arming IDLE.
REQ-028 Stop bit low otherwise: set FRAME_ERR and discard the character.
REQ-029 Parity mismatch: set PARITY_ERR and still push the character.
REQ-030 A push while the RX FIFO is full sets OVERRUN_ERR, drops the new character and keeps the FIFO contents.
REQ-031 A push with a simultaneous RX_READ on a full RX FIFO is accepted (no overrun).
REQ-032 TX_WRITE while TX_FULL is ignored; it is accepted only if the TX FSM pops in the same cycle.
REQ-033 RX_READ while RX_VALID=0 is ignored.
REQ-034 Push-to-RX_VALID latency is 1 cycle; pop-to-next-head latency is 1 cycle.
REQ-035 ERR_CLEAR has priority over a same-cycle error set; clear wins.
REQ-036 FIFO pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.

Reset
REQ-037 RST low asynchronously forces: TX=1, both FSMs to IDLE, baud counter 0, both FIFOs empty (TX_EMPTY=1, TX_FULL=0, RX_VALID=0, RX_FULL=0), RX_DATA=0, all error flags 0, synchroniser flops 1.
REQ-038 Reset during a character aborts it; no partial character is pushed, and TX returns high immediately.

Structure
REQ-039 Package uart_pkg holds the PARITY_NONE/EVEN/ODD constants and the TX and RX state encodings.
REQ-040 One sub-module, uart_fifo (parametrised width and depth, FWFT), is instantiated twice.

Verification (CLOCK=1600000, BAUD_RATE=100000 -> DIV=1, 16 cycles/bit)
REQ-041 Write 0xA5 (8 data bits, odd parity) -> TX sequence 0,1,0,1,0,0,1,0,1,1,1 over 176 cycles; TX_EMPTY=1 after the pop.
REQ-042 TX looped to RX, 17 writes 0x00..0x10 with no reads -> 16 read back in order; 17th dropped, OVERRUN_ERR=1.
REQ-043 Inject 0x3C with the wrong parity -> RX_DATA=0x3C, RX_VALID=1, PARITY_ERR=1; ERR_CLEAR -> 0.
REQ-044 Inject a 0x55 frame with the stop bit low -> FRAME_ERR=1, RX_VALID=0; a 12-bit-time low -> BREAK_DET=1, nothing pushed.
REQ-045 A 5-cycle low RX glitch -> no state change; RST low mid-TX-character -> TX=1 and FIFOs empty in the same cycle.
